// File: rtl/deck_dealer_if.sv
// Controller <-> deck_dealer handshake bundle.
// The controller drives the requests; the dealer drives status and card data.
interface deck_dealer_if;
   logic       shuffle_req;
   logic       card_req;
   logic       busy;
   logic       shuffle_done;
   logic       card_valid;
   logic [3:0] card_rank;
   logic [1:0] card_suit;
   logic [5:0] cards_remaining;
   logic       deck_empty;

   modport master (
      output shuffle_req, card_req,
      input  busy, shuffle_done, card_valid, card_rank, card_suit,
             cards_remaining, deck_empty
   );

   modport slave (
      input  shuffle_req, card_req,
      output busy, shuffle_done, card_valid, card_rank, card_suit,
             cards_remaining, deck_empty
   );
endinterface

// File: rtl/deck_dealer.sv
// 52-card deck responder: builds the deck, optionally Fisher-Yates shuffles it
// (enabled by defining DEALER_SHUFFLE_EN), then deals one card per request.
module deck_dealer #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   deck_dealer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, INIT, PICK, SWAP, READY} state_t;

   state_t      state, state_nxt;
   logic [5:0]  deck [0:51];
   logic [5:0]  k, i, j, ptr, rem;
   logic [15:0] lfsr;
   logic [5:0]  cand;
   logic        deal_go, pick_ok;
   logic        vld_p1, done_p1;
   logic [3:0]  rank_p1;
   logic [1:0]  suit_p1;

   // Card ID -> {rank, suit}; rank 1..13, suit 0..3.
   function automatic logic [5:0] card_of(input logic [5:0] id);
      logic [1:0] s;
      logic [3:0] r;
      s = (id >= 6'd39) ? 2'd3 : (id >= 6'd26) ? 2'd2 : (id >= 6'd13) ? 2'd1 : 2'd0;
      r = 4'(id - 6'(s * 6'd13)) + 4'd1;
      return {r, s};
   endfunction

   assign cand = lfsr[5:0];

   always_comb begin
      state_nxt = state;
      deal_go   = 1'b0;
      pick_ok   = 1'b0;
      case (state)
         IDLE:  if (bus.shuffle_req) state_nxt = INIT;
         INIT:  if (k == 6'd51) begin
`ifdef DEALER_SHUFFLE_EN
            state_nxt = PICK;
`else
            state_nxt = READY;
`endif
         end
         // Rejection sampling: retry until the candidate falls inside 0..i.
         PICK:  if (cand <= i) begin
            pick_ok   = 1'b1;
            state_nxt = SWAP;
         end
         SWAP:  state_nxt = (i == 6'd1) ? READY : PICK;
         READY: if (bus.shuffle_req) state_nxt = INIT;
                else if (bus.card_req && rem != 6'd0) deal_go = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   // Control state and registered outputs (p1 = one cycle after the request edge).
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lfsr    <= LFSR_SEED;
         rem     <= 6'd0;
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
         rank_p1 <= 4'd0;
         suit_p1 <= 2'd0;
      end else begin
         state   <= state_nxt;
         lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         vld_p1  <= deal_go;
         done_p1 <= (state_nxt == READY) && (state != READY);
         if (state_nxt == INIT && state != INIT)
            rem <= 6'd0;
         else if (state_nxt == READY && state != READY)
            rem <= 6'd52;
         else if (deal_go)
            rem <= rem - 6'd1;
         if (deal_go)
            {rank_p1, suit_p1} <= card_of(deck[ptr]);
      end
   end

   // Deck storage and indices; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      k <= (state == INIT) ? k + 6'd1 : 6'd0;
      if (state == INIT) begin
         deck[k] <= k;
         i       <= 6'd51;
      end else if (state == SWAP) begin
         deck[i] <= deck[j];
         deck[j] <= deck[i];
         i       <= i - 6'd1;
      end
      if (pick_ok)
         j <= cand;
      if (state_nxt == READY && state != READY)
         ptr <= 6'd0;
      else if (deal_go)
         ptr <= ptr + 6'd1;
   end

   assign bus.busy            = (state == INIT) || (state == PICK) || (state == SWAP);
   assign bus.shuffle_done    = done_p1;
   assign bus.card_valid      = vld_p1;
   assign bus.card_rank       = rank_p1;
   assign bus.card_suit       = suit_p1;
   assign bus.cards_remaining = rem;
   assign bus.deck_empty      = (rem == 6'd0);
endmodule

// File: tb/tb_deck_dealer.sv
// Self-checking bench for deck_dealer; expectations come from a deck model
// (ordered IDs by default, permutation/determinism checks with DEALER_SHUFFLE_EN).
module tb_deck_dealer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   deck_dealer_if bus();
   deck_dealer #(.LFSR_SEED(16'hACE1)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int exp_rem;
   int dealt[$];
   int seq_a[$];
   int seq_b[$];
   bit seen[52];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.shuffle_req = 1'b0;
      bus.card_req = 1'b0;
      repeat (3) step();
      rst = 1'b0;
   endtask

   task automatic start_shuffle(input bit with_card);
      bus.shuffle_req = 1'b1;
      bus.card_req = with_card;
      step();
      bus.shuffle_req = 1'b0;
      bus.card_req = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", bus.busy); end
      checks++; if (bus.cards_remaining !== 6'd0) begin errors++; $display("FAIL start_remaining: got %0d expected 0", bus.cards_remaining); end
      checks++; if (bus.card_valid !== 1'b0) begin errors++; $display("FAIL start_card_valid: got %b expected 0", bus.card_valid); end
   endtask

   task automatic wait_ready();
      int lat = 1;
      int bad = 0;
      while (bus.shuffle_done !== 1'b1 && lat < 3000) begin
         if (bus.busy !== 1'b1 || bus.cards_remaining !== 6'd0 || bus.deck_empty !== 1'b1) bad++;
         step();
         lat++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL shuffle_status: %0d bad cycles, expected 0", bad); end
      checks++; if (bus.shuffle_done !== 1'b1) begin errors++; $display("FAIL shuffle_timeout: shuffle_done=%b after %0d cycles", bus.shuffle_done, lat); end
`ifdef DEALER_SHUFFLE_EN
      checks++; if (lat < 155) begin errors++; $display("FAIL shuffle_latency: got %0d expected >= 155", lat); end
`else
      checks++; if (lat != 53) begin errors++; $display("FAIL shuffle_latency: got %0d expected 53", lat); end
`endif
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ready_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.cards_remaining !== 6'd52) begin errors++; $display("FAIL ready_remaining: got %0d expected 52", bus.cards_remaining); end
      checks++; if (bus.deck_empty !== 1'b0) begin errors++; $display("FAIL ready_empty: got %b expected 0", bus.deck_empty); end
      step();
      checks++; if (bus.shuffle_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", bus.shuffle_done); end
      exp_rem = 52;
      dealt.delete();
      foreach (seen[x]) seen[x] = 1'b0;
   endtask

   task automatic deal(input int n, input bit b2b);
      for (int c = 0; c < n; c++) begin
         int pos, id, g;
         bus.card_req = 1'b1;
         step();
         if (!b2b) bus.card_req = 1'b0;
         pos = 52 - exp_rem;
         exp_rem--;
         id = int'(bus.card_suit) * 13 + int'(bus.card_rank) - 1;
         checks++; if (bus.card_valid !== 1'b1) begin errors++; $display("FAIL card_valid[%0d]: got %b expected 1", pos, bus.card_valid); end
         checks++; if (bus.cards_remaining !== 6'(exp_rem)) begin errors++; $display("FAIL remaining[%0d]: got %0d expected %0d", pos, bus.cards_remaining, exp_rem); end
`ifdef DEALER_SHUFFLE_EN
         checks++;
         if (bus.card_rank < 1 || bus.card_rank > 13 || id < 0 || id > 51 || seen[id]) begin
            errors++; $display("FAIL card_unique[%0d]: got rank %0d suit %0d, expected an undealt card", pos, bus.card_rank, bus.card_suit);
         end else seen[id] = 1'b1;
`else
         checks++;
         if (bus.card_rank !== 4'(pos % 13 + 1) || bus.card_suit !== 2'(pos / 13)) begin
            errors++; $display("FAIL card_order[%0d]: got rank %0d suit %0d expected rank %0d suit %0d",
                              pos, bus.card_rank, bus.card_suit, pos % 13 + 1, pos / 13);
         end
`endif
         dealt.push_back(id);
         if (!b2b) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               step();
               checks++;
               if (bus.card_valid !== 1'b0 || int'(bus.card_suit) * 13 + int'(bus.card_rank) - 1 != id) begin
                  errors++; $display("FAIL gap_hold[%0d]: valid %b id %0d, expected valid 0 id %0d", pos, bus.card_valid,
                                     int'(bus.card_suit) * 13 + int'(bus.card_rank) - 1, id);
               end
            end
         end
      end
      bus.card_req = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.shuffle_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.shuffle_done); end
      checks++; if (bus.card_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.card_valid); end
      checks++; if (bus.card_rank !== 4'd0 || bus.card_suit !== 2'd0) begin errors++; $display("FAIL rst_card: got rank %0d suit %0d expected 0 0", bus.card_rank, bus.card_suit); end
      checks++; if (bus.cards_remaining !== 6'd0) begin errors++; $display("FAIL rst_remaining: got %0d expected 0", bus.cards_remaining); end
      checks++; if (bus.deck_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", bus.deck_empty); end
      bus.card_req = 1'b1;
      step();
      bus.card_req = 1'b0;
      checks++; if (bus.card_valid !== 1'b0) begin errors++; $display("FAIL idle_card_req: got valid %b expected 0", bus.card_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_full_deck();
      repeat ($urandom_range(0, 5)) step();
      start_shuffle(1'b0);
      wait_ready();
      deal(52, 1'b0);
`ifndef DEALER_SHUFFLE_EN
      checks++; if (bus.card_rank !== 4'd13 || bus.card_suit !== 2'd3) begin errors++; $display("FAIL last_card: got rank %0d suit %0d expected 13 3", bus.card_rank, bus.card_suit); end
`endif
      checks++; if (bus.deck_empty !== 1'b1) begin errors++; $display("FAIL empty_after_deal: got %b expected 1", bus.deck_empty); end
      bus.card_req = 1'b1;
      step();
      bus.card_req = 1'b0;
      checks++; if (bus.card_valid !== 1'b0) begin errors++; $display("FAIL extra_card: got valid %b expected 0", bus.card_valid); end
      checks++; if (bus.cards_remaining !== 6'd0) begin errors++; $display("FAIL extra_remaining: got %0d expected 0", bus.cards_remaining); end
   endtask

   task automatic test_back_to_back();
      start_shuffle(1'b0);
      wait_ready();
      deal(52, 1'b1);
      step();
      checks++; if (bus.card_valid !== 1'b0) begin errors++; $display("FAIL b2b_stop: got valid %b expected 0", bus.card_valid); end
      checks++; if (bus.cards_remaining !== 6'd0) begin errors++; $display("FAIL b2b_remaining: got %0d expected 0", bus.cards_remaining); end
   endtask

   task automatic test_collision();
      start_shuffle(1'b0);
      wait_ready();
      deal(12, 1'b0);
      checks++; if (bus.cards_remaining !== 6'd40) begin errors++; $display("FAIL pre_collision: got %0d expected 40", bus.cards_remaining); end
      start_shuffle(1'b1);
      wait_ready();
      deal(52, 1'b1);
   endtask

   task automatic test_mid_reset();
      int pulses = 0;
      start_shuffle(1'b0);
`ifdef DEALER_SHUFFLE_EN
      repeat ($urandom_range(60, 150)) step();
`else
      repeat ($urandom_range(3, 45)) step();
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.cards_remaining !== 6'd0 || bus.deck_empty !== 1'b1) begin errors++; $display("FAIL midrst_remaining: got %0d empty %b expected 0 1", bus.cards_remaining, bus.deck_empty); end
      checks++; if (bus.card_rank !== 4'd0 || bus.card_valid !== 1'b0) begin errors++; $display("FAIL midrst_card: got rank %0d valid %b expected 0 0", bus.card_rank, bus.card_valid); end
      repeat (500) begin
         if (bus.shuffle_done === 1'b1 || bus.busy !== 1'b0) pulses++;
         step();
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", pulses); end
   endtask

   task automatic test_determinism();
      int diff = 0;
      for (int run = 0; run < 2; run++) begin
         do_reset();
         repeat (7) step();
         start_shuffle(1'b0);
         wait_ready();
         deal(52, 1'b1);
         if (run == 0) seq_a = dealt; else seq_b = dealt;
      end
      checks++; if (seq_a.size() != 52 || seq_b.size() != 52) begin errors++; $display("FAIL det_size: got %0d/%0d expected 52", seq_a.size(), seq_b.size()); end
      for (int x = 0; x < seq_a.size() && x < seq_b.size(); x++)
         if (seq_a[x] != seq_b[x]) diff++;
      checks++; if (diff != 0) begin errors++; $display("FAIL det_sequence: got %0d differing cards expected 0", diff); end
   endtask

   initial begin
      test_reset();
      test_full_deck();
      test_back_to_back();
      test_collision();
      test_mid_reset();
      test_determinism();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/deck_dealer.md
# deck_dealer

Card-deck responder for the blackjack controller. Holds a 52-card deck in registers, builds and (optionally) Fisher-Yates shuffles it on a controller request, then serves one card per request over a request/valid handshake. Sits beside `controller`; the controller is the initiator, `deck_dealer` the responder.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded on reset; must be nonzero.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `shuffle_req` input 1: request a new deck; sampled in IDLE or READY only.
- `card_req` input 1: request next card; sampled in READY only.
- `busy` output 1: high in INIT, PICK and SWAP.
- `shuffle_done` output 1: one-cycle pulse on entry to READY.
- `card_valid` output 1: one-cycle pulse; `card_rank`/`card_suit` are valid this cycle.
- `card_rank` output 4: 1=Ace, 2..10, 11=J, 12=Q, 13=K; holds last value between cards.
- `card_suit` output 2: 0..3.
- `cards_remaining` output 6: undealt cards, 0..52.
- `deck_empty` output 1: `cards_remaining == 0`.

## Operation
- Storage: 52 × 6-bit card IDs `deck[0..51]`; rank = id mod 13 + 1, suit = id / 13. Deal pointer `ptr` is 6 bits.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle in every state; only reset reloads `LFSR_SEED`.
- States:
  - IDLE: reset state. `shuffle_req` → INIT, `k=0`. `card_req` is ignored.
  - INIT: writes `deck[k]=k`, one entry per cycle, for k=0..51. After k=51, goes to PICK with `i=51` (shuffle compiled in) or to READY (compiled out).
  - PICK: candidate `j = lfsr[5:0]`. If `j <= i`, latch j and go to SWAP; otherwise stay (rejection sampling).
  - SWAP: exchange `deck[i]` and `deck[j]` in one cycle; `i=i-1`. If the old i was 1, go to READY; else go to PICK.
  - READY: entered with `ptr=0`, `cards_remaining=52`, and `shuffle_done` pulsed.
- Dealing, in READY:
  - `card_req` with `cards_remaining>0` outputs `deck[ptr]`, then `ptr+1` and `cards_remaining-1`.
  - `card_req` with `cards_remaining==0` is ignored: no `card_valid`, no state change.
- Simultaneous `shuffle_req` and `card_req` in READY: the shuffle wins, the card request is dropped, and the next state is INIT.
- `shuffle_req` during INIT, PICK or SWAP is ignored and not queued.
- `cards_remaining` is forced to 0 on entry to INIT and stays 0 until READY.
- Reset mid-operation: next cycle state=IDLE and all outputs at reset values. Deck contents are don't-care; no `shuffle_done` pulse follows.

## Timing
- Reset values: `busy=0`, `shuffle_done=0`, `card_valid=0`, `card_rank=0`, `card_suit=0`, `cards_remaining=0`, `deck_empty=1`; LFSR = `LFSR_SEED`.
- `shuffle_req` sampled high at edge N: `busy=1` from cycle N+1.
  - INIT occupies cycles N+1..N+52.
  - Shuffle compiled out: READY and `shuffle_done` in cycle N+53; `busy=0` in that cycle.
  - Shuffle compiled in: latency is 52 INIT cycles plus 51 SWAP cycles plus PICK cycles (≥51, variable, deterministic for a given seed and request cycle).
- `card_req` sampled at edge M: `card_valid`, rank and suit are registered outputs in cycle M+1. `cards_remaining` updates in the same cycle M+1.
- `card_req` held high continuously: one card per cycle until empty.

## Configuration
- `DEALER_SHUFFLE_EN` defined: PICK/SWAP shuffle runs after INIT.
- `DEALER_SHUFFLE_EN` undefined: INIT goes directly to READY and the deck is dealt in ID order 0..51 (ordered deck for directed tests). LFSR logic may be removed.

## Test plan
- Reset: `rst` high 3 cycles → all outputs at reset values; `deck_empty=1`; `card_req` pulse in IDLE gives no `card_valid`.
- Ordered deck (macro undefined): `shuffle_req` at edge N → `shuffle_done` in cycle N+53. Then 52 consecutive `card_req` → cards rank 1..13 with suit 0, then suits 1, 2, 3 in order. Final card is rank 13 suit 3; after it `cards_remaining=0` and `deck_empty=1`.
- Shuffle (macro defined): shuffle, then deal 52 → every ID 0..51 appears exactly once. A 53rd `card_req` gives no `card_valid`.
- Collision: in READY with 40 cards remaining, `shuffle_req` and `card_req` high in the same cycle → no `card_valid`, `busy=1` next cycle, `cards_remaining=0` until `shuffle_done`, then 52.
- Reset mid-shuffle: `rst` during PICK/SWAP → next cycle `busy=0` and `cards_remaining=0`; no `shuffle_done` pulse within 500 cycles.
- Determinism: two runs with identical reset and request timing → identical 52-card sequences. A different `LFSR_SEED` gives a different sequence.
